// File: rtl/wishbone_stream_adapter.sv
// Wishbone stream adapter.
// Unpack path: splits each 32-bit istream word into SPW samples, LSB lane first.
// Pack path: gathers SPW results into one 32-bit ostream word.
// A flush pulse emits a partially packed word with its unfilled upper lanes zeroed.
module wishbone_stream_adapter #(
  parameter int p_sample_nbits = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      istream_val,
  output logic                      istream_rdy,
  input  logic [31:0]               istream_data,
  output logic                      samp_val,
  input  logic                      samp_rdy,
  output logic [p_sample_nbits-1:0] samp_data,
  input  logic                      res_val,
  output logic                      res_rdy,
  input  logic [p_sample_nbits-1:0] res_data,
  input  logic                      flush,
  output logic                      ostream_val,
  input  logic                      ostream_rdy,
  output logic [31:0]               ostream_data
);

  localparam int SPW = 32 / p_sample_nbits;
  localparam int IW  = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SPW - 1);

  if ((p_sample_nbits != 8) && (p_sample_nbits != 16) && (p_sample_nbits != 32)) begin : g_bad_width
    $error("wishbone_stream_adapter: p_sample_nbits must be 8, 16 or 32");
  end

  // Replaces lane idx of word with d.
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [IW-1:0] idx,
                                              input logic [p_sample_nbits-1:0] d);
    logic [31:0] r;
    r = word;
    r[idx*p_sample_nbits +: p_sample_nbits] = d;
    return r;
  endfunction

  // ---------------- unpack path ----------------
  // ubuf is shifted down one lane per accepted sample, so the current sample
  // always sits in the low lane and samp_data comes straight from a register.
  logic [31:0]   ubuf_q, ubuf_d;
  logic [IW-1:0] uidx_q, uidx_d;
  logic          ufull_q, ufull_d;
  logic          samp_fire_s, istream_fire_s, ulast_s;

  assign samp_val       = ufull_q;
  assign samp_data      = ubuf_q[p_sample_nbits-1:0];
  assign samp_fire_s    = ufull_q && samp_rdy;
  assign ulast_s        = (uidx_q == LAST_IDX);
  assign istream_rdy    = !ufull_q || (samp_fire_s && ulast_s);
  assign istream_fire_s = istream_val && istream_rdy;

  // Unpack next state: load a new word, or advance to the next sample.
  always_comb begin
    ubuf_d  = ubuf_q;
    uidx_d  = uidx_q;
    ufull_d = ufull_q;
    if (istream_fire_s) begin
      ubuf_d  = istream_data;
      uidx_d  = '0;
      ufull_d = 1'b1;
    end else if (samp_fire_s) begin
      ubuf_d = ubuf_q >> p_sample_nbits;
      if (ulast_s) begin
        uidx_d  = '0;
        ufull_d = 1'b0;
      end else begin
        uidx_d  = uidx_q + IW'(1);
        ufull_d = 1'b1;
      end
    end else begin
      ufull_d = ufull_q;
    end
  end

  // Unpack state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ubuf_q  <= 32'd0;
      uidx_q  <= '0;
      ufull_q <= 1'b0;
    end else begin
      ubuf_q  <= ubuf_d;
      uidx_q  <= uidx_d;
      ufull_q <= ufull_d;
    end
  end

  // ---------------- pack path ----------------
  logic [31:0]   pacc_q, pacc_d;
  logic [IW-1:0] pcnt_q, pcnt_d;
  logic [31:0]   obuf_q, obuf_d;
  logic          oval_q, oval_d;
  logic          fpend_q, fpend_d;
  logic          ostream_fire_s, slot_free_s, res_fire_s, plast_s, drain_s;

  assign ostream_val    = oval_q;
  assign ostream_data   = obuf_q;
  assign ostream_fire_s = oval_q && ostream_rdy;
  assign slot_free_s    = !oval_q || ostream_fire_s;
  assign plast_s        = (pcnt_q == LAST_IDX);
  // A pending flush owns the output slot until it drains.
  assign res_rdy        = (fpend_q && !slot_free_s) ? 1'b0 : (slot_free_s || !plast_s);
  assign res_fire_s     = res_val && res_rdy;
  assign drain_s        = fpend_q && slot_free_s;

  // Pack next state: drain a pending flush, accumulate results, complete words.
  always_comb begin
    pacc_d  = pacc_q;
    pcnt_d  = pcnt_q;
    obuf_d  = obuf_q;
    oval_d  = ostream_fire_s ? 1'b0 : oval_q;
    fpend_d = fpend_q;
    if (drain_s) begin
      // The flushed partial word is older than any result arriving now, so a
      // result accepted in this cycle starts the next word in lane 0.
      obuf_d  = pacc_q;
      oval_d  = 1'b1;
      fpend_d = 1'b0;
      if (res_fire_s) begin
        pacc_d = lane_insert(32'd0, '0, res_data);
        pcnt_d = IW'(1);
      end else begin
        pacc_d = 32'd0;
        pcnt_d = '0;
      end
    end else if (res_fire_s) begin
      if (plast_s) begin
        obuf_d = lane_insert(pacc_q, pcnt_q, res_data);
        oval_d = 1'b1;
        pacc_d = 32'd0;
        pcnt_d = '0;
      end else begin
        pacc_d = lane_insert(pacc_q, pcnt_q, res_data);
        pcnt_d = pcnt_q + IW'(1);
      end
    end else begin
      pacc_d = pacc_q;
    end
    // A flush that leaves nothing partial (empty, or the result completes the word) is dropped.
    if (flush && !fpend_q && (SPW > 1) && ((pcnt_q != '0) || res_fire_s)
        && !(res_fire_s && plast_s)) begin
      fpend_d = 1'b1;
    end else begin
      fpend_d = fpend_d;
    end
  end

  // Pack state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pacc_q  <= 32'd0;
      pcnt_q  <= '0;
      obuf_q  <= 32'd0;
      oval_q  <= 1'b0;
      fpend_q <= 1'b0;
    end else begin
      pacc_q  <= pacc_d;
      pcnt_q  <= pcnt_d;
      obuf_q  <= obuf_d;
      oval_q  <= oval_d;
      fpend_q <= fpend_d;
    end
  end

endmodule

// File: doc/wishbone_stream_adapter.md
Name: wishbone_stream_adapter

Overview:
- Sits directly downstream of the Wishbone stream bridge's istream port and directly upstream of its ostream port.
- Unpack path: splits each 32-bit word written by firmware into p_sample_nbits-wide samples for an accelerator, LSB first.
- Pack path: gathers accelerator results of the same width back into 32-bit words for firmware to read.
- Both paths use val/rdy handshakes and run independently.

Parameters:
- p_sample_nbits, 8: sample width in bits. Legal values are 8, 16 and 32; any other value is an elaboration error.
- SPW (localparam), 32/p_sample_nbits: number of samples per word.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- istream_val  in  1  word valid from the bridge.
- istream_rdy  out  1  adapter can accept a word.
- istream_data  in  32  word from the bridge.
- samp_val  out  1  sample valid to the accelerator.
- samp_rdy  in  1  accelerator accepts the sample.
- samp_data  out  p_sample_nbits  sample data.
- res_val  in  1  result valid from the accelerator.
- res_rdy  out  1  adapter accepts the result.
- res_data  in  p_sample_nbits  result data.
- flush  in  1  single-cycle pulse: emit the partial packed word, zero-padded.
- ostream_val  out  1  packed word valid to the bridge.
- ostream_rdy  in  1  bridge accepts the packed word.
- ostream_data  out  32  packed word.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; all state clears immediately when reset is asserted.
- Reset values:
  - istream_rdy=1, samp_val=0, samp_data=0.
  - res_rdy=1, ostream_val=0, ostream_data=0.
  - All counters, buffers and the flush-pending flag are 0.
- Handshake rule: a transfer ("fire") happens on a rising edge where val&&rdy. val must not depend combinationally on rdy.
- Unpack state:
  - ubuf (32-bit word register), uidx (sample index, 0..SPW-1), ufull (buffer-valid flag).
  - samp_val=ufull.
  - samp_data=ubuf[uidx*p_sample_nbits +: p_sample_nbits].
  - istream_rdy = !ufull || (samp_fire && uidx==SPW-1). This allows a new word to load in the same cycle the last sample leaves.
- Unpack events:
  - istream fire: ubuf<=istream_data, uidx<=0, ufull<=1. The first sample is visible the next cycle (latency 1).
  - samp fire with uidx<SPW-1: uidx increments.
  - samp fire with uidx==SPW-1: uidx<=0; ufull<=0 unless an istream fire occurs in the same cycle.
  - Throughput: one sample per cycle is sustained across word boundaries.
  - samp_rdy low: samp_data and uidx hold.
- Pack state:
  - pacc (32-bit accumulator), pcnt (count, 0..SPW-1), obuf (output register, drives ostream_data), ostream_val (output-valid flag), fpend (flush-pending flag).
  - slot_free = !ostream_val || ostream_fire.
  - res_rdy = slot_free || pcnt<SPW-1.
- Pack events:
  - res fire: pacc[pcnt*p_sample_nbits +: p_sample_nbits]<=res_data.
  - If that fills the word (pcnt==SPW-1): obuf<=completed word, ostream_val<=1, pacc<=0, pcnt<=0. Otherwise pcnt increments.
  - ostream fire with no new completion in that cycle: ostream_val<=0.
- Flush:
  - flush with pcnt==0 and no res fire that cycle: no effect.
  - Otherwise fpend<=1. While fpend is set and slot_free, the partial word moves to obuf with unfilled upper lanes zero, then pcnt<=0, pacc<=0, fpend<=0.
  - flush in the same cycle as a res fire: the result is included before padding.
  - res_rdy=0 while fpend is set and the slot is not free.
  - flush while fpend is already set: ignored.
  - With p_sample_nbits=32, flush is always a no-op.
- Reset mid-operation: partially unpacked and partially packed words are discarded. No output handshake completes during reset.

Test Plan:
- Unpack, basic (p_sample_nbits=8): istream word 0x44332211, samp_rdy=1 → samp_data 0x11, 0x22, 0x33, 0x44 on four consecutive cycles starting 1 cycle after the fire; istream_rdy=1 again in the 0x44 cycle.
- Unpack, back-to-back: words 0x44332211 and 0x88776655 with istream_val held → 8 samples in 8 consecutive cycles with no bubble; samp_rdy toggled low in cycle 2 → 0x33 held until accepted.
- Pack, basic: results 0xA1, 0xA2, 0xA3, 0xA4 → ostream_data=0xA4A3A2A1, ostream_val=1 the cycle after the 0xA4 fire.
- Pack, backpressure: ostream_rdy=0 and 8 results 0x01..0x08 → first word 0x04030201 held; res_rdy drops after 0x07 is accepted; after ostream_rdy=1, second word 0x08070605 follows.
- Flush: results 0xB1, 0xB2 then flush pulse → 0x0000B2B1. Flush with pcnt==0 → no ostream_val. Flush in the same cycle as 0xC1 → 0x000000C1.
- Reset mid-operation: reset asserted (active-low) after 2 samples unpacked and 1 result packed → asynchronous clear; after release, samp_val=0, ostream_val=0, and the next results pack from lane 0.
